exc_ctrl: RTL

- Exception request controller ahead of the pipeline exception unit.
- Collects one internal synchronous fault (invalid opcode) and NIRQ external interrupt lines, holds them as pending, and picks one by fixed priority.
- Drives Exc/EStatus into the exception unit, then sequences the handshake: raise, wait for ExcAck, stay in handler, and return on ERet.
- Only one exception is in service at a time; later requests wait in the pending register.

---
 rtl/exc_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/exc_ctrl.sv
// exc_ctrl - exception request controller ahead of the pipeline exception unit.
//
// Collects the invalid-opcode fault and NIRQ external interrupt lines into a
// pending register, picks one by fixed priority (invop, then IRQ0, IRQ1, ...),
// and runs the Exc / ExcAck / ERet handshake with the exception unit.
// Only one exception is in service at a time.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   exc_invop    one-cycle invalid-opcode pulse from decode
//   irq_req      level interrupt requests, rising edges are captured
//   irq_en       global IRQ enable (does not gate exc_invop)
//   ExcAck       exception unit has fetched the vector
//   ERet         ERET executing in EX
//   Exc          exception request to the exception unit
//   EStatus      cause code: 1 = invop, 2+i = IRQ i
//   irq_ack      one-hot one-cycle pulse when IRQ i is selected
//   busy         high whenever the FSM is not IDLE
//   exc_timeout  sticky ack-timeout flag
//
// Optional feature macro: EXC_TIMEOUT_EN
//   Defined   : SIGNAL is abandoned after TIMEOUT cycles without ExcAck and
//               exc_timeout is set until reset.
//   Undefined : no counter, exc_timeout tied low, SIGNAL waits indefinitely.

module exc_ctrl #(
  parameter int NIRQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exc_invop,
  input  logic [NIRQ-1:0] irq_req,
  input  logic            irq_en,
  input  logic            ExcAck,
  input  logic            ERet,
  output logic            Exc,
  output logic [3:0]      EStatus,
  output logic [NIRQ-1:0] irq_ack,
  output logic            busy,
  output logic            exc_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SIGNAL  = 2'd1,
    ST_HANDLER = 2'd2,
    ST_RETURN  = 2'd3
  } state_t;

  // An out-of-range configuration never raises an exception.
  localparam bit CFG_OK = (NIRQ >= 1) && (NIRQ <= 12) && (TIMEOUT >= 1);
  localparam logic [NIRQ:0] ONE_V = {{NIRQ{1'b0}}, 1'b1};

  // Isolate the lowest set bit: lowest index has highest priority.
  function automatic logic [NIRQ:0] pick_lowest(input logic [NIRQ:0] v);
    return v & (~v + ONE_V);
  endfunction

  state_t          state_r, state_nxt_s;
  logic [NIRQ:0]   pending_r, pending_nxt_s;
  logic [NIRQ-1:0] irq_q_r;
  logic [NIRQ-1:0] rise_s;
  logic [NIRQ:0]   set_s, clr_s, elig_s, sel_s;
  logic [3:0]      sel_code_s;
  logic            any_s;
  logic            exc_r, exc_nxt_s;
  logic [3:0]      estatus_r, estatus_nxt_s;
  logic [NIRQ-1:0] irq_ack_r, irq_ack_nxt_s;
  logic            busy_r, busy_nxt_s;

`ifdef EXC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             tmo_r, tmo_nxt_s;
`endif

  // Capture: set wins over clear of the same bit in the same cycle.
  assign rise_s        = irq_req & ~irq_q_r;
  assign set_s         = {rise_s, exc_invop};
  assign pending_nxt_s = (pending_r & ~clr_s) | set_s;
  // Masked IRQs stay pending; only the invop bit ignores irq_en.
  assign elig_s        = pending_r & {{NIRQ{irq_en}}, 1'b1};
  assign sel_s         = pick_lowest(elig_s);
  assign any_s         = CFG_OK & (|elig_s);

  // Encode the selected one-hot bit b into cause code b+1.
  always_comb begin
    sel_code_s = 4'h0;
    for (int b = 0; b <= NIRQ; b++) begin
      sel_code_s = sel_code_s | (sel_s[b] ? 4'(b + 1) : 4'h0);
    end
  end

  // Next-state and next-output logic of the handshake FSM.
  always_comb begin
    state_nxt_s   = state_r;
    exc_nxt_s     = exc_r;
    estatus_nxt_s = estatus_r;
    irq_ack_nxt_s = '0;
    clr_s         = '0;
`ifdef EXC_TIMEOUT_EN
    cnt_nxt_s     = cnt_r;
    tmo_nxt_s     = tmo_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          estatus_nxt_s = sel_code_s;
          clr_s         = sel_s;
          exc_nxt_s     = 1'b1;
          irq_ack_nxt_s = sel_s[NIRQ:1];
          state_nxt_s   = ST_SIGNAL;
`ifdef EXC_TIMEOUT_EN
          cnt_nxt_s     = '0;
`endif
        end else begin
          exc_nxt_s = 1'b0;
        end
      end
      ST_SIGNAL: begin
        // ExcAck wins over a timeout expiring in the same cycle.
        if (ExcAck) begin
          exc_nxt_s   = 1'b0;
          state_nxt_s = ST_HANDLER;
        end
`ifdef EXC_TIMEOUT_EN
        else if (cnt_r == CNT_LAST) begin
          exc_nxt_s     = 1'b0;
          estatus_nxt_s = 4'h0;
          tmo_nxt_s     = 1'b1;
          state_nxt_s   = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
`else
        else begin
          exc_nxt_s = 1'b1;
        end
`endif
      end
      ST_HANDLER: begin
        exc_nxt_s = 1'b0;
        if (ERet) begin
          state_nxt_s = ST_RETURN;
        end else begin
          state_nxt_s = ST_HANDLER;
        end
      end
      ST_RETURN: begin
        exc_nxt_s     = 1'b0;
        estatus_nxt_s = 4'h0;
        state_nxt_s   = ST_IDLE;
      end
      default: begin
        exc_nxt_s     = 1'b0;
        estatus_nxt_s = 4'h0;
        state_nxt_s   = ST_IDLE;
      end
    endcase
  end

  assign busy_nxt_s = (state_nxt_s != ST_IDLE);

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      exc_r     <= 1'b0;
      estatus_r <= 4'h0;
      irq_ack_r <= '0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      exc_r     <= exc_nxt_s;
      estatus_r <= estatus_nxt_s;
      irq_ack_r <= irq_ack_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  // Request capture: edge detector history and pending register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q_r   <= '0;
      pending_r <= '0;
    end else begin
      irq_q_r   <= irq_req;
      pending_r <= pending_nxt_s;
    end
  end

`ifdef EXC_TIMEOUT_EN
  // Ack-timeout counter and sticky flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
      tmo_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      tmo_r <= tmo_nxt_s;
    end
  end
  assign exc_timeout = tmo_r;
`else
  assign exc_timeout = 1'b0;
`endif

  assign Exc     = exc_r;
  assign EStatus = estatus_r;
  assign irq_ack = irq_ack_r;
  assign busy    = busy_r;

endmodule
